// File: rtl/arb_mux_n.sv
// N-way registered mux with valid/ready on every channel and on the output.
// MODE=0 picks the channel named by sel; MODE=1 round-robins over in_valid.
// A single output register isolates the select path from the consumer.

// Per-channel accept: this channel is taken when it holds the grant and
// the output register can load. Held low while reset is asserted.
module arb_mux_n_lane #(
   parameter int SELW = 3,
   parameter int IDX  = 0
) (
   input  logic            rst_n,
   input  logic            load,
   input  logic            grant_valid,
   input  logic [SELW-1:0] grant,
   output logic            ready
);
   assign ready = rst_n & load & grant_valid & (grant == SELW'(IDX));
endmodule

module arb_mux_n #(
   parameter int WIDTH = 32,
   parameter int N     = 8,
   parameter int SELW  = $clog2(N),
   parameter int MODE  = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [SELW-1:0]    sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_src
);

   logic [N-1:0][WIDTH-1:0] ch;
   logic [SELW-1:0]         rr_ptr;
   logic [SELW-1:0]         grant;
   logic                    grant_valid;
   logic                    load;

   // Register is free when empty or being drained at this edge.
   assign load = ~out_valid | out_ready;

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_lane
         assign ch[g] = in_data[g*WIDTH +: WIDTH];
         arb_mux_n_lane #(.SELW(SELW), .IDX(g)) u_lane (
            .rst_n       (rst_n),
            .load        (load),
            .grant_valid (grant_valid),
            .grant       (grant),
            .ready       (in_ready[g])
         );
      end
   endgenerate

   // Grant selection: explicit select (out-of-range sel matches no lane),
   // or first valid channel searching upward from rr_ptr+1, wrapping at N.
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      if (MODE == 0) begin
         for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               grant_valid = 1'b1;
               grant       = SELW'(i);
            end
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            logic [SELW:0]   sum;
            logic [SELW-1:0] idx;
            sum = {1'b0, rr_ptr} + (SELW+1)'(k);
            if (sum >= (SELW+1)'(N))
               sum = sum - (SELW+1)'(N);
            idx = sum[SELW-1:0];
            if (!grant_valid && in_valid[idx]) begin
               grant_valid = 1'b1;
               grant       = idx;
            end
         end
      end
   end

   // Output register: load on a grant, empty on a drain with nothing to load,
   // otherwise hold. rr_ptr only moves on an actual transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         rr_ptr    <= SELW'(N-1);
      end else if (load) begin
         if (grant_valid) begin
            out_valid <= 1'b1;
            out_data  <= ch[grant];
            out_src   <= grant;
            rr_ptr    <= grant;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: explicit-select table (N=8), out-of-range select
// (N=5), and round-robin sequences with stall and async reset (N=8).
module tb_arb_mux_n;

   logic clk, rst_n;

   logic [7:0]   iv0, rdy0, iv1, rdy1;
   logic [2:0]   sel0, os0, sel1, os1, sel2, os2;
   logic         ordy0, ov0, ordy1, ov1, ordy2, ov2;
   logic [255:0] idata0, idata1;
   logic [31:0]  od0, od1, od2;
   logic [4:0]   iv2, rdy2;
   logic [159:0] idata2;

   arb_mux_n #(.WIDTH(32), .N(8), .SELW(3), .MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(rdy0), .in_data(idata0),
      .sel(sel0), .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_src(os0));
   arb_mux_n #(.WIDTH(32), .N(8), .SELW(3), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .in_data(idata1),
      .sel(sel1), .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_src(os1));
   arb_mux_n #(.WIDTH(32), .N(5), .SELW(3), .MODE(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2), .in_data(idata2),
      .sel(sel2), .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .out_src(os2));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  iv;
      logic [2:0]  sel;
      logic        ordy;
      logic [7:0]  rdy;
      logic        ov;
      logic [31:0] od;
      logic [2:0]  os;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic [2:0]  s;
   } exp_t;

   vec_t        tbl[12];
   exp_t        q0[$], q1[$];
   logic [31:0] chdat[8];
   int          n_cmp = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Pop and compare when the consumer takes a word at the coming edge.
   task sb0();
      exp_t e;
      if (ov0 && ordy0) begin
         if (q0.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb0_unexpected: got src %0d expected no word", os0);
         end else begin
            e = q0.pop_front();
            chk("sb0_data", od0, e.d);
            chk("sb0_src", 32'(os0), 32'(e.s));
         end
      end
   endtask

   task sb1();
      exp_t e;
      if (ov1 && ordy1) begin
         if (q1.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb1_unexpected: got src %0d expected no word", os1);
         end else begin
            e = q1.pop_front();
            chk("sb1_data", od1, e.d);
            chk("sb1_src", 32'(os1), 32'(e.s));
         end
      end
   endtask

   initial begin
      chdat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                32'h55555555, 32'hDEADBEEF, 32'h77777777, 32'h88888888};
      for (int i = 0; i < 8; i++) begin
         idata0[i*32 +: 32] = chdat[i];
         idata1[i*32 +: 32] = chdat[i];
      end
      for (int i = 0; i < 5; i++) idata2[i*32 +: 32] = chdat[i];

      //           iv     sel   ordy  rdy    ov    od             os
      tbl[0]  = '{8'h20, 3'd5, 1'b1, 8'h20, 1'b1, 32'hDEADBEEF, 3'd5};
      tbl[1]  = '{8'h01, 3'd2, 1'b1, 8'h00, 1'b0, 32'hDEADBEEF, 3'd5};
      tbl[2]  = '{8'h01, 3'd0, 1'b1, 8'h01, 1'b1, 32'h11111111, 3'd0};
      tbl[3]  = '{8'hFF, 3'd7, 1'b0, 8'h00, 1'b1, 32'h11111111, 3'd0};
      tbl[4]  = '{8'hFF, 3'd7, 1'b1, 8'h80, 1'b1, 32'h88888888, 3'd7};
      tbl[5]  = '{8'hFF, 3'd3, 1'b1, 8'h08, 1'b1, 32'h44444444, 3'd3};
      tbl[6]  = '{8'h00, 3'd3, 1'b1, 8'h00, 1'b0, 32'h44444444, 3'd3};
      tbl[7]  = '{8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 32'h44444444, 3'd3};
      tbl[8]  = '{8'h04, 3'd2, 1'b0, 8'h04, 1'b1, 32'h33333333, 3'd2};
      tbl[9]  = '{8'h04, 3'd2, 1'b0, 8'h00, 1'b1, 32'h33333333, 3'd2};
      tbl[10] = '{8'h40, 3'd6, 1'b1, 8'h40, 1'b1, 32'h77777777, 3'd6};
      tbl[11] = '{8'h40, 3'd5, 1'b1, 8'h00, 1'b0, 32'h77777777, 3'd6};

      clk = 0; rst_n = 0;
      iv0 = 8'hFF; sel0 = 3'd5; ordy0 = 1;
      iv1 = 8'hFF; sel1 = 3'd0; ordy1 = 1;
      iv2 = 5'h1F; sel2 = 3'd4; ordy2 = 1;

      // Reset held for three cycles with valid inputs present
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rdy0", 32'(rdy0), 0);
      chk("rst_rdy1", 32'(rdy1), 0);
      chk("rst_rdy2", 32'(rdy2), 0);
      chk("rst_ov0", 32'(ov0), 0);
      chk("rst_od0", od0, 0);
      chk("rst_os0", 32'(os0), 0);
      chk("rst_ov1", 32'(ov1), 0);
      iv0 = 0; iv1 = 0; iv2 = 0;
      rst_n = 1;
      @(posedge clk); #1;
      chk("post_rst_ov0", 32'(ov0), 0);
      chk("post_rst_ov1", 32'(ov1), 0);

      // Explicit select table
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         iv0 = tbl[i].iv; sel0 = tbl[i].sel; ordy0 = tbl[i].ordy;
         #1;
         chk($sformatf("t%0d_rdy", i), 32'(rdy0), 32'(tbl[i].rdy));
         sb0();
         if (tbl[i].rdy != 0) q0.push_back({chdat[tbl[i].sel], tbl[i].sel});
         @(posedge clk); #1;
         chk($sformatf("t%0d_ov", i), 32'(ov0), 32'(tbl[i].ov));
         chk($sformatf("t%0d_od", i), od0, tbl[i].od);
         chk($sformatf("t%0d_os", i), 32'(os0), 32'(tbl[i].os));
      end
      @(negedge clk);
      iv0 = 0; ordy0 = 1;
      #1; sb0();
      chk("q0_empty", q0.size(), 0);

      // Out-of-range select never grants (N=5)
      @(negedge clk); iv2 = 5'h1F; sel2 = 3'd6; #1;
      chk("n5_sel6_rdy", 32'(rdy2), 0);
      @(posedge clk); #1;
      chk("n5_sel6_ov", 32'(ov2), 0);
      @(negedge clk); sel2 = 3'd7; #1;
      chk("n5_sel7_rdy", 32'(rdy2), 0);
      @(negedge clk); sel2 = 3'd4; #1;
      chk("n5_sel4_rdy", 32'(rdy2), 32'h10);
      @(posedge clk); #1;
      chk("n5_sel4_ov", 32'(ov2), 1);
      chk("n5_sel4_od", od2, chdat[4]);
      chk("n5_sel4_os", 32'(os2), 4);
      @(negedge clk); iv2 = 0;

      // Round-robin with all channels valid: 0..7,0,1 back to back
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         iv1 = 8'hFF; ordy1 = 1;
         #1;
         sb1();
         if (k > 0) chk($sformatf("rr%0d_nogap", k), 32'(ov1), 1);
         chk($sformatf("rr%0d_rdy", k), 32'(rdy1), 32'(1) << (k % 8));
         q1.push_back({chdat[k % 8], 3'(k % 8)});
      end
      @(negedge clk);
      iv1 = 8'h08; #1;
      sb1();
      chk("rr_ch3_rdy", 32'(rdy1), 32'h08);
      q1.push_back({chdat[3], 3'd3});

      // Stall holding channel 3's word
      repeat (4) begin
         @(negedge clk);
         iv1 = 8'hFF; ordy1 = 0; #1;
         chk("stall_rdy", 32'(rdy1), 0);
         chk("stall_ov", 32'(ov1), 1);
         chk("stall_os", 32'(os1), 3);
         chk("stall_od", od1, chdat[3]);
         sb1();
      end
      @(negedge clk);
      ordy1 = 1; #1;
      chk("unstall_rdy", 32'(rdy1), 32'h10);
      sb1();
      q1.push_back({chdat[4], 3'd4});
      @(negedge clk); #1;
      chk("rr_ch5_rdy", 32'(rdy1), 32'h20);
      sb1();
      q1.push_back({chdat[5], 3'd5});

      // Async reset mid-cycle discards the held word
      @(posedge clk); #2;
      chk("pre_arst_ov", 32'(ov1), 1);
      rst_n = 0; #1;
      chk("arst_ov", 32'(ov1), 0);
      chk("arst_od", od1, 0);
      chk("arst_rdy", 32'(rdy1), 0);
      q1.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      iv1 = 0; rst_n = 1;

      // Sequence restarts at channel 0
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         iv1 = 8'hFF; ordy1 = 1; #1;
         sb1();
         chk($sformatf("rs%0d_rdy", k), 32'(rdy1), 32'(1) << k);
         q1.push_back({chdat[k], 3'(k)});
      end
      @(negedge clk);
      iv1 = 0; #1;
      sb1();
      @(posedge clk); #1;
      chk("final_ov1", 32'(ov1), 0);
      chk("q1_empty", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
